bmi_calc: RTL and testbench
===========================

Name: bmi_calc

Overview:
- Downstream consumer of the per-user height/weight store (32 entries, combinational read by index).
- On a start request for one user index it drives the store's index and captures height (cm) and weight (kg).
- It computes BMI x10 with a one-bit-per-cycle restoring divider and classifies the result into a 2-bit category.
- Results are presented with a busy/done handshake to the control/display logic.

Parameters:
- IDX_W, 5, user index width (32 users).
- DATA_W, 32, width of the height/weight words read from the store.
- OP_W, 16, usable operand bits; upper DATA_W-OP_W bits must be zero.
- NUM_W, 34, numerator/quotient width; equals the number of divider iterations.
- SCALE, 100000, numerator multiplier: cm^2 to m^2 (10000) times x10 output scaling.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- start  in  1  request; accepted only in IDLE.
- user_index  in  IDX_W  user to evaluate; sampled with an accepted start.
- mem_index  out  IDX_W  index driven to the store's read port.
- height_in  in  DATA_W  store height_out, combinational on mem_index.
- weight_in  in  DATA_W  store weight_out, combinational on mem_index.
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle completion pulse.
- bmi_x10  out  16  BMI x10, truncated and saturated.
- category  out  2  0 under (<185), 1 normal (185..249), 2 over (250..299), 3 obese (>=300).
- error  out  1  result invalid (zero height or operand out of range).

Behaviour:
- reset is asynchronous, active-high; clk is the clock. During reset: state=IDLE; busy, done, error=0; bmi_x10=0; category=0; mem_index=0; all internal registers=0.
- FSM IDLE -> FETCH -> SETUP -> DIV -> DONE -> IDLE.
- IDLE: start=1 at edge E0 latches user_index into mem_index, busy=1, next state FETCH. start=0 keeps the block in IDLE.
- FETCH, one cycle: at E1 latch height_in[OP_W-1:0] and weight_in[OP_W-1:0].
  - If height[15:0]==0, or any of height_in[31:16] / weight_in[31:16] is nonzero, flag the error and go to DONE.
  - Otherwise go to SETUP.
- SETUP, one cycle: at E2 load numerator = weight*SCALE (NUM_W bits, no overflow since 65535*100000 < 2^33), divisor = height*height (32 bits), remainder=0, iteration count=0.
- DIV: one restoring step per cycle, MSB first.
  - Shift remainder left with the next numerator bit.
  - If remainder >= divisor, subtract and set the quotient bit to 1.
  - Exactly NUM_W steps, at edges E3..E36.
- DONE: output registers update on the edge entering DONE.
  - Normal path (E36): bmi_x10 = quotient if quotient <= 65535, else 16'hFFFF; category from bmi_x10 using the thresholds above; error=0.
  - Error path (E1): bmi_x10=0, category=0, error=1.
  - done=1 and busy=1 for exactly the one cycle in DONE. Next edge: IDLE, done=0, busy=0.
- Latency: the normal-path done cycle immediately follows E36 (36 edges after the start-accept edge). The error-path done cycle immediately follows E1.
- bmi_x10, category and error hold their values until the next DONE entry; they are not cleared when a new start is accepted.
- start while not IDLE (including the DONE cycle) is ignored and never queued. user_index changes while busy have no effect.
- mem_index holds its value after completion until the next accepted start.
- Store writes to the selected user during FETCH are seen only if they land before E1. Operands are frozen after E1.
- Reset mid-operation aborts immediately: IDLE, all outputs at reset values, no done pulse.
- Division is truncating (floor). Category compares use bmi_x10 after saturation.

Test Plan:
- Store user 3 = 175 cm / 70 kg; start, index 3 -> mem_index=3; done one cycle after E36; bmi_x10=228, category=1, error=0; busy high E0..done cycle.
- User 7 = 160/90 -> bmi_x10=351, category=3. User 9 = 180/50 -> bmi_x10=154, category=0. Back-to-back starts: each done pulse is exactly 1 cycle wide.
- User 0 height 0, weight 60 -> done one cycle after E1; error=1, bmi_x10=0, category=0. Height 32'h0001_0000 -> error=1.
- Height 1 / weight 65535 -> quotient 6553500000 saturates: bmi_x10=65535, category=3, error=0.
- Start pulse held high through the whole operation with user_index changed mid-run -> single completion, result for the originally latched index; no retrigger in the DONE cycle.
- Assert reset at the DIV midpoint (cycle ~20) -> busy=0, done never pulses, outputs 0. A new start after release yields the correct 228 for user 3.

Source files
------------

// File: rtl/bmi_calc.sv
`default_nettype none
// ============================================================================
// Module   : bmi_calc
// Function : Reads height/weight for one user from the store and computes
//            BMI x10 with a bit-serial restoring divider, then classifies it.
// Revision : 1.0
// ============================================================================
module bmi_calc #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32,
  parameter int OP_W   = 16,
  parameter int NUM_W  = 34,
  parameter int SCALE  = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  user_index,
  output logic [IDX_W-1:0]  mem_index,
  input  logic [DATA_W-1:0] height_in,
  input  logic [DATA_W-1:0] weight_in,
  output logic              busy,
  output logic              done,
  output logic [15:0]       bmi_x10,
  output logic [1:0]        category,
  output logic              error
);

  localparam int CNT_W = $clog2(NUM_W);
  localparam int DIV_W = 2 * OP_W;
  localparam logic [NUM_W-1:0] SCALE_N  = NUM_W'(SCALE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SETUP = 3'd2,
    DIV   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [OP_W-1:0]  height, weight;
  logic [NUM_W-1:0] numer, quot, quot_nxt;
  logic [DIV_W-1:0] divisor, rem, rem_nxt;
  logic [DIV_W:0]   rem_shift, rem_diff;
  logic [CNT_W-1:0] count;
  logic             qbit, last_step, op_bad;
  logic [15:0]      bmi_sat;
  logic [1:0]       cat_nxt;

  // Upper operand bits must be clear and height must be nonzero.
  assign op_bad = (height_in[OP_W-1:0] == '0) ||
                  (|height_in[DATA_W-1:OP_W]) ||
                  (|weight_in[DATA_W-1:OP_W]);

  // One restoring division step, MSB of the numerator first.
  assign rem_shift = {rem, numer[NUM_W-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor};
  assign qbit      = (rem_shift >= {1'b0, divisor});
  assign rem_nxt   = qbit ? rem_diff[DIV_W-1:0] : rem_shift[DIV_W-1:0];
  assign quot_nxt  = {quot[NUM_W-2:0], qbit};
  assign last_step = (count == LAST_CNT);

  assign bmi_sat = (|quot_nxt[NUM_W-1:16]) ? 16'hFFFF : quot_nxt[15:0];

  always_comb begin
    cat_nxt = 2'd0;
    if (bmi_sat >= 16'd300)      cat_nxt = 2'd3;
    else if (bmi_sat >= 16'd250) cat_nxt = 2'd2;
    else if (bmi_sat >= 16'd185) cat_nxt = 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = op_bad ? DONE : SETUP;
      SETUP:   state_nxt = DIV;
      DIV:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bmi_x10   <= '0;
      category  <= '0;
      error     <= 1'b0;
      height    <= '0;
      weight    <= '0;
      numer     <= '0;
      divisor   <= '0;
      rem       <= '0;
      quot      <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem_index <= user_index;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          height <= height_in[OP_W-1:0];
          weight <= weight_in[OP_W-1:0];
          if (op_bad) begin
            bmi_x10  <= '0;
            category <= '0;
            error    <= 1'b1;
            done     <= 1'b1;
          end
        end
        SETUP: begin
          numer   <= NUM_W'(weight) * SCALE_N;
          divisor <= DIV_W'(height) * DIV_W'(height);
          rem     <= '0;
          quot    <= '0;
          count   <= '0;
        end
        DIV: begin
          numer <= numer << 1;
          rem   <= rem_nxt;
          quot  <= quot_nxt;
          count <= count + CNT_W'(1);
          if (last_step) begin
            bmi_x10  <= bmi_sat;
            category <= cat_nxt;
            error    <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bmi_calc.sv
`default_nettype none
// Testbench for bmi_calc: table of per-user vectors plus hand-written
// sequences for held start, reset abort and recovery.
module tb_bmi_calc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  user_index = '0;
  logic [4:0]  mem_index;
  logic [31:0] height_in, weight_in;
  logic        busy, done, error;
  logic [15:0] bmi_x10;
  logic [1:0]  category;

  logic [31:0] st_h [32];
  logic [31:0] st_w [32];

  assign height_in = st_h[mem_index];
  assign weight_in = st_w[mem_index];

  always #5 clk = ~clk;

  bmi_calc dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .user_index (user_index),
    .mem_index  (mem_index),
    .height_in  (height_in),
    .weight_in  (weight_in),
    .busy       (busy),
    .done       (done),
    .bmi_x10    (bmi_x10),
    .category   (category),
    .error      (error)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] h;
    logic [31:0] w;
    logic [15:0] bmi;
    logic [1:0]  cat;
    logic        err;
    int          lat;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one edge, then count edges until done (bounded).
  task automatic run_op(input logic [4:0] idx, output int lat, output bit busy_ok);
    @(negedge clk);
    start = 1'b1;
    user_index = idx;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_ok = busy;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
    end
  endtask

  vec_t vecs [13];

  initial begin
    int  lat;
    bit  bok;
    int  dones;
    int  done_at;

    for (int i = 0; i < 32; i++) begin
      st_h[i] = '0;
      st_w[i] = '0;
    end
    //         idx    height        weight        bmi     cat  err lat
    vecs[0]  = '{5'd3,  32'd175,      32'd70,       16'd228,   2'd1, 1'b0, 36};
    vecs[1]  = '{5'd7,  32'd160,      32'd90,       16'd351,   2'd3, 1'b0, 36};
    vecs[2]  = '{5'd9,  32'd180,      32'd50,       16'd154,   2'd0, 1'b0, 36};
    vecs[3]  = '{5'd0,  32'd0,        32'd60,       16'd0,     2'd0, 1'b1, 1};
    vecs[4]  = '{5'd1,  32'h0001_0000,32'd60,       16'd0,     2'd0, 1'b1, 1};
    vecs[5]  = '{5'd2,  32'd1,        32'd65535,    16'd65535, 2'd3, 1'b0, 36};
    vecs[6]  = '{5'd4,  32'd170,      32'h0001_0040,16'd0,     2'd0, 1'b1, 1};
    vecs[7]  = '{5'd10, 32'd200,      32'd73,       16'd182,   2'd0, 1'b0, 36};
    vecs[8]  = '{5'd11, 32'd200,      32'd74,       16'd185,   2'd1, 1'b0, 36};
    vecs[9]  = '{5'd12, 32'd200,      32'd99,       16'd247,   2'd1, 1'b0, 36};
    vecs[10] = '{5'd13, 32'd200,      32'd100,      16'd250,   2'd2, 1'b0, 36};
    vecs[11] = '{5'd14, 32'd200,      32'd119,      16'd297,   2'd2, 1'b0, 36};
    vecs[12] = '{5'd15, 32'd200,      32'd120,      16'd300,   2'd3, 1'b0, 36};
    foreach (vecs[i]) begin
      st_h[vecs[i].idx] = vecs[i].h;
      st_w[vecs[i].idx] = vecs[i].w;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_bmi", bmi_x10, 0);
    check("rst_cat", category, 0);
    check("rst_mem_index", mem_index, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].idx, lat, bok);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i), bok, 1);
      check($sformatf("v%0d_mem_index", i), mem_index, vecs[i].idx);
      check($sformatf("v%0d_bmi", i), bmi_x10, vecs[i].bmi);
      check($sformatf("v%0d_cat", i), category, vecs[i].cat);
      check($sformatf("v%0d_err", i), error, vecs[i].err);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_width", i), done, 0);
      check($sformatf("v%0d_busy_clear", i), busy, 0);
      check($sformatf("v%0d_bmi_hold", i), bmi_x10, vecs[i].bmi);
    end

    // Start held high through the run, user_index changed mid-run.
    @(negedge clk);
    start = 1'b1;
    user_index = 5'd3;
    @(posedge clk);
    #1;
    dones = 0;
    done_at = 0;
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) user_index = 5'd7;
      if (done) begin
        dones++;
        done_at = c;
      end
    end
    start = 1'b0;
    check("held_done_count", dones, 1);
    check("held_done_at", done_at, 36);
    check("held_bmi", bmi_x10, 228);
    check("held_mem_index", mem_index, 3);
    @(posedge clk);
    #1;
    check("held_no_retrigger", busy, 0);
    @(posedge clk);
    #1;
    check("held_idle", busy, 0);

    // Reset in the middle of the division.
    @(negedge clk);
    start = 1'b1;
    user_index = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bmi", bmi_x10, 0);
    check("abort_cat", category, 0);
    check("abort_mem_index", mem_index, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    check("abort_quiet", dones, 0);
    run_op(5'd3, lat, bok);
    check("recover_latency", lat, 36);
    check("recover_busy", bok, 1);
    check("recover_bmi", bmi_x10, 228);
    check("recover_cat", category, 1);
    check("recover_err", error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
